// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload controller and its quiet timer.
package nvram_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAITD, DONE} upl_state_t;
    localparam logic [7:0] NV_INDEX_DEFAULT = 8'd4;
    localparam logic [7:0] OOR_FILL         = 8'hFF;
endpackage

// File: rtl/nvram_quiet_timer.sv
// Autosave quiet timer: reloads on every CMOS write, counts down while enabled,
// and emits a single save pulse per write burst.
module nvram_quiet_timer #(
    parameter logic [23:0] QUIET_CYC = 24'd4_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_reload,
    input  logic i_run,
    output logic o_pulse
);
    logic [23:0] r_cnt;
    logic        r_armed;
    logic        r_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (i_reload) begin
                r_cnt   <= QUIET_CYC;
                r_armed <= 1'b1;
            end else if (i_run && r_armed) begin
                // Disarm after firing so a quiet period yields only one request.
                if (r_cnt <= 24'd1) begin
                    r_cnt   <= '0;
                    r_armed <= 1'b0;
                    r_pulse <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 24'd1;
                end
            end
        end
    end

    assign o_pulse = r_pulse;
endmodule

// File: rtl/nvram_upload_ctrl.sv
// Serves the NVRAM image to the HPS over the ioctl upload channel and tracks dirtiness.
// Optional autosave request generation is enabled with NVRAM_AUTOSAVE_EN.
module nvram_upload_ctrl
    import nvram_pkg::*;
#(
    parameter int          AW        = 10,
    parameter logic [7:0]  NV_INDEX  = NV_INDEX_DEFAULT,
    parameter int          RD_LAT    = 1,
    parameter logic [23:0] QUIET_CYC = 24'd4_000_000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] nv_addr,
    output logic          nv_rd,
    input  logic [7:0]    nv_q,
    input  logic          cpu_nv_we,
    output logic          nv_dirty,
    output logic          save_req,
    output upl_state_t    dbg_state
);
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  FULL     = {1'b1, {AW{1'b0}}};
    localparam logic [1:0]     LAT_INIT = 2'(RD_LAT);

    upl_state_t    r_state;
    upl_state_t    w_next;
    logic [24:0]   r_addr;
    logic [1:0]    r_lat;
    logic          r_wait;
    logic [7:0]    r_din;
    logic [AW-1:0] r_nv_addr;
    logic [CW-1:0] r_cnt;
    logic          r_active_q;
    logic          r_dirty;
    logic          w_active;
    logic          w_start;
    logic          w_in_range;
    logic          w_rise;
    logic          w_fall;
    logic          w_nv_rd;

    assign w_active   = ioctl_upload && (ioctl_index == NV_INDEX);
    assign w_start    = (r_state == IDLE) && ioctl_rd && w_active;
    assign w_in_range = (r_addr[24:AW] == '0);
    assign w_rise     = w_active && !r_active_q;
    assign w_fall     = !w_active && r_active_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Losing the upload overrides every state so a mid-fetch abort never latches data.
    always_comb begin
        w_next  = r_state;
        w_nv_rd = 1'b0;
        if (!w_active) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (ioctl_rd) w_next = ISSUE;
                ISSUE: begin
                    w_nv_rd = w_in_range;
                    w_next  = w_in_range ? WAITD : DONE;
                end
                WAITD:   if (r_lat == 2'd1) w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_lat      <= '0;
            r_wait     <= 1'b0;
            r_din      <= 8'h00;
            r_nv_addr  <= '0;
            r_cnt      <= '0;
            r_active_q <= 1'b0;
            r_dirty    <= 1'b0;
        end else begin
            r_active_q <= w_active;
            r_wait     <= (w_next == ISSUE) || (w_next == WAITD);
            if (w_start) begin
                r_addr <= ioctl_addr;
                if (ioctl_addr[24:AW] == '0) r_nv_addr <= ioctl_addr[AW-1:0];
            end
            if (r_state == ISSUE)      r_lat <= LAT_INIT;
            else if (r_state == WAITD) r_lat <= r_lat - 2'd1;
            if (w_next == DONE && r_state == ISSUE)      r_din <= OOR_FILL;
            else if (w_next == DONE && r_state == WAITD) r_din <= nv_q;
            // Only strictly sequential bytes count toward a complete image.
            if (w_rise)
                r_cnt <= '0;
            else if (r_state == DONE && w_active && r_cnt != FULL &&
                     r_addr == {{(25-CW){1'b0}}, r_cnt})
                r_cnt <= r_cnt + 1'b1;
            if (cpu_nv_we)                     r_dirty <= 1'b1;
            else if (w_fall && r_cnt == FULL)  r_dirty <= 1'b0;
        end
    end

    // Handshake: ioctl_rd is a one-cycle request; ioctl_wait is high from that cycle
    // until ioctl_din holds the requested byte, and the HPS samples data once it falls.
    assign ioctl_wait = r_wait || w_start;
    assign ioctl_din  = r_din;
    assign nv_addr    = r_nv_addr;
    assign nv_rd      = w_nv_rd;
    assign nv_dirty   = r_dirty;
    assign dbg_state  = r_state;

`ifdef NVRAM_AUTOSAVE_EN
    nvram_quiet_timer #(
        .QUIET_CYC (QUIET_CYC)
    ) u_quiet_timer (
        .clk      (clk_sys),
        .rst      (reset),
        .i_reload (cpu_nv_we),
        .i_run    (r_dirty && !w_active),
        .o_pulse  (save_req)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^QUIET_CYC;
    assign save_req     = 1'b0;
`endif
endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Directed bench for nvram_upload_ctrl with a behavioural NVRAM and an expected-data queue.
module tb_nvram_upload_ctrl;
  import nvram_pkg::*;

  localparam int AW = 10;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic [AW-1:0] nv_addr;
  logic          nv_rd;
  logic [7:0]    nv_q;
  logic          cpu_nv_we;
  logic          nv_dirty;
  logic          save_req;
  upl_state_t    dbg_state;

  int total = 0;
  int bad = 0;
  int nv_rd_cnt = 0;
  logic [7:0] mem [0:1023];
  logic [7:0] exp_q[$];

  always #5 clk_sys = ~clk_sys;

  nvram_upload_ctrl #(
    .AW        (AW),
    .NV_INDEX  (8'd4),
    .RD_LAT    (1),
    .QUIET_CYC (24'd100)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .nv_addr      (nv_addr),
    .nv_rd        (nv_rd),
    .nv_q         (nv_q),
    .cpu_nv_we    (cpu_nv_we),
    .nv_dirty     (nv_dirty),
    .save_req     (save_req),
    .dbg_state    (dbg_state)
  );

  // NVRAM model, one cycle latency; output is junk when not being read.
  always @(posedge clk_sys) begin
    if (nv_rd) begin
      nv_q      <= mem[nv_addr];
      nv_rd_cnt <= nv_rd_cnt + 1;
    end else begin
      nv_q <= 8'($urandom);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 in IDLE; returns at posedge+1 of the next IDLE cycle.
  task automatic do_req(input logic [24:0] addr, input logic [7:0] exp, input int exp_wait);
    int n;
    logic [7:0] e;
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    exp_q.push_back(exp);
    #1;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 20) begin
      n++;
      @(posedge clk_sys); #1;
      ioctl_rd  = 1'b0;
      cpu_nv_we = 1'b0;
      #1;
    end
    ioctl_rd  = 1'b0;
    cpu_nv_we = 1'b0;
    chk("wait_cycles", n, exp_wait);
    e = exp_q.pop_front();
    chk("rd_data", ioctl_din, e);
    @(posedge clk_sys); #1;
  endtask

  task automatic full_upload();
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < 1024; i++) begin
      if (i == 500) cpu_nv_we = 1'b1;
      do_req(25'(i), mem[i], 3);
    end
  endtask

  initial begin
    int base;
    int pulses;
    int first;
    logic [7:0] din0;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = '0; cpu_nv_we = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_sys); #1;
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_nv_addr", nv_addr, '0);
    chk("rst_nv_rd", nv_rd, 1'b0);
    chk("rst_dirty", nv_dirty, 1'b0);
    chk("rst_save_req", save_req, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    @(posedge clk_sys); #1;

    cpu_nv_we = 1'b1;
    @(posedge clk_sys); #1;
    cpu_nv_we = 1'b0;
    chk("we_sets_dirty", nv_dirty, 1'b1);

    // Wrong index is ignored
    ioctl_upload = 1'b1; ioctl_index = 8'd1;
    @(posedge clk_sys); #1;
    base = nv_rd_cnt; din0 = ioctl_din;
    ioctl_addr = 25'd5; ioctl_rd = 1'b1; #1;
    chk("wrongidx_wait_now", ioctl_wait, 1'b0);
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    chk("wrongidx_wait_next", ioctl_wait, 1'b0);
    chk("wrongidx_state", dbg_state, IDLE);
    repeat (3) @(posedge clk_sys); #1;
    chk("wrongidx_nv_rd", nv_rd_cnt, base);
    chk("wrongidx_din", ioctl_din, din0);
    ioctl_upload = 1'b0;
    @(posedge clk_sys); #1;

    // Full upload, then out-of-range, then completion clears dirty
    base = nv_rd_cnt;
    full_upload();
    chk("full_nv_rd_count", nv_rd_cnt - base, 1024);
    base = nv_rd_cnt;
    do_req(25'd1024, 8'hFF, 2);
    chk("oor_no_nv_rd", nv_rd_cnt, base);
    chk("dirty_during_upload", nv_dirty, 1'b1);
    ioctl_upload = 1'b0;
    @(posedge clk_sys); #1;
    chk("dirty_cleared_after_full", nv_dirty, 1'b0);

    // Write coinciding with the end of a complete upload keeps dirty
    full_upload();
    ioctl_upload = 1'b0; cpu_nv_we = 1'b1;
    @(posedge clk_sys); #1;
    cpu_nv_we = 1'b0;
    chk("race_dirty", nv_dirty, 1'b1);

    // Abort during WAITD
    ioctl_upload = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < 100; i++) do_req(25'(i), mem[i], 3);
    ioctl_addr = 25'd100; ioctl_rd = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    chk("abort_in_issue", dbg_state, ISSUE);
    @(posedge clk_sys); #1;
    chk("abort_in_waitd", dbg_state, WAITD);
    ioctl_upload = 1'b0;
    @(posedge clk_sys); #1;
    chk("abort_wait", ioctl_wait, 1'b0);
    chk("abort_state", dbg_state, IDLE);
    chk("abort_dirty", nv_dirty, 1'b1);
    repeat (2) @(posedge clk_sys); #1;
    chk("abort_din_held", ioctl_din, mem[99]);

`ifdef NVRAM_AUTOSAVE_EN
    cpu_nv_we = 1'b1;
    @(posedge clk_sys); #1;
    cpu_nv_we = 1'b0;
    pulses = 0; first = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk_sys); #1;
      if (save_req) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("autosave_delay", first, 100);
    chk("autosave_pulses", pulses, 1);
    cpu_nv_we = 1'b1;
    @(posedge clk_sys); #1;
    cpu_nv_we = 1'b0;
    pulses = 0; first = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk_sys); #1;
      if (k == 49) cpu_nv_we = 1'b1;
      if (k == 50) cpu_nv_we = 1'b0;
      if (save_req) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("autosave_retrigger_delay", first, 150);
    chk("autosave_retrigger_pulses", pulses, 1);
`else
    cpu_nv_we = 1'b1;
    @(posedge clk_sys); #1;
    cpu_nv_we = 1'b0;
    pulses = 0; first = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk_sys); #1;
      if (save_req !== 1'b0) pulses++;
    end
    chk("save_req_tied_low", pulses, first);
`endif

    // Asynchronous reset in the middle of a fetch
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    @(posedge clk_sys); #1;
    ioctl_addr = 25'd7; ioctl_rd = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    @(posedge clk_sys); #1;
    chk("arst_pre_wait", ioctl_wait, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_wait", ioctl_wait, 1'b0);
    chk("arst_din", ioctl_din, 8'h00);
    chk("arst_dirty", nv_dirty, 1'b0);
    chk("arst_nv_addr", nv_addr, '0);
    chk("arst_state", dbg_state, IDLE);
    ioctl_upload = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
